uvma_axis_prot_chkr: RTL and testbench

Parametrised, synthesizable AXI4-Stream protocol checker that passively observes one AXI-Stream link and flags handshake, stability, packet-framing and timeout violations. Errors are reported as a registered per-cycle vector, sticky flags and a first-error code, with saturating beat and packet counters. It sits beside the AXI-Stream agent interface in the testbench and in emulation builds, and can be bound to any DUT AXI-Stream port.

---
 rtl/uvma_axis_prot_chkr_pkg.sv | 23 ++
 rtl/uvma_axis_prot_chkr_stall_trk.sv | 45 ++++
 rtl/uvma_axis_prot_chkr.sv | 117 +++++++++++
 tb/tb_uvma_axis_prot_chkr.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uvma_axis_prot_chkr_pkg.sv
// Shared error indices, framing state and helpers for the AXI-Stream protocol checker.
package uvma_axis_prot_chkr_pkg;

    localparam int ERR_W = 6;

    localparam logic [2:0] ERR_VALID_DROP   = 3'd0;
    localparam logic [2:0] ERR_PAYLOAD_CHG  = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT      = 3'd2;
    localparam logic [2:0] ERR_PKT_LONG     = 3'd3;
    localparam logic [2:0] ERR_ROUTE_CHG    = 3'd4;
    localparam logic [2:0] ERR_STRB_NO_KEEP = 3'd5;
    localparam logic [2:0] ERR_NONE         = 3'd7;

    typedef enum logic {IDLE, IN_PKT} pkt_state_e;

    // Lowest set bit wins; ERR_NONE when the vector is empty.
    function automatic logic [2:0] first_err_idx(input logic [ERR_W-1:0] v);
        first_err_idx = ERR_NONE;
        for (int i = ERR_W - 1; i >= 0; i--)
            if (v[i]) first_err_idx = 3'(i);
    endfunction

endpackage

// File: rtl/uvma_axis_prot_chkr_stall_trk.sv
// Tracks stalled beats: payload hold check, valid-drop check and stall timeout.
module uvma_axis_prot_chkr_stall_trk #(
    parameter int PW             = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          tvalid,
    input  logic          tready,
    input  logic [PW-1:0] payload,
    output logic          valid_drop,
    output logic          payload_chg,
    output logic          timeout
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 2) : 1;

    logic          stall;
    logic          stall_q;
    logic [PW-1:0] cap_q;
    logic [TW-1:0] stall_cnt;

    assign stall = tvalid & ~tready;

    // Counter parks one past the limit so the timeout match is a single pulse per episode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q   <= 1'b0;
            cap_q     <= '0;
            stall_cnt <= '0;
        end else begin
            stall_q <= stall;
            if (stall) cap_q <= payload;
            if (!stall)
                stall_cnt <= '0;
            else if (stall_cnt != TW'(TIMEOUT_CYCLES + 1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign valid_drop  = stall_q & ~tvalid;
    assign payload_chg = stall_q & tvalid & (payload != cap_q);
    assign timeout     = (TIMEOUT_CYCLES > 0) && (stall_cnt == TW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/uvma_axis_prot_chkr.sv
// Passive AXI4-Stream protocol checker: framing, routing and strobe rules plus error aggregation.
module uvma_axis_prot_chkr
    import uvma_axis_prot_chkr_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int DEST_WIDTH     = 4,
    parameter int USER_WIDTH     = 1,
    parameter int MAX_PKT_BEATS  = 256,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clr_i,
    input  logic                    tvalid,
    input  logic                    tready,
    input  logic                    tlast,
    input  logic [DATA_WIDTH-1:0]   tdata,
    input  logic [DATA_WIDTH/8-1:0] tstrb,
    input  logic [DATA_WIDTH/8-1:0] tkeep,
    input  logic [ID_WIDTH-1:0]     tid,
    input  logic [DEST_WIDTH-1:0]   tdest,
    input  logic [USER_WIDTH-1:0]   tuser,
    output logic [ERR_W-1:0]        err_vec_o,
    output logic                    err_o,
    output logic [ERR_W-1:0]        err_sticky_o,
    output logic [2:0]              first_err_o,
    output logic [CNT_WIDTH-1:0]    beat_cnt_o,
    output logic [CNT_WIDTH-1:0]    pkt_cnt_o
);

    localparam int SW  = DATA_WIDTH / 8;
    localparam int PW  = DATA_WIDTH + 2 * SW + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
    localparam int PBW = (MAX_PKT_BEATS > 0) ? $clog2(MAX_PKT_BEATS + 1) : 1;

    logic                  hs;
    logic                  valid_drop, payload_chg, timeout;
    logic                  pkt_long, route_chg, strb_no_keep;
    logic [ERR_W-1:0]      err_now;
    pkt_state_e            state;
    logic [PBW-1:0]        pkt_beats, beats_eff;
    logic [ID_WIDTH-1:0]   cap_id;
    logic [DEST_WIDTH-1:0] cap_dest;

    assign hs = tvalid & tready;

    uvma_axis_prot_chkr_stall_trk #(
        .PW             (PW),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_stall_trk (
        .clk         (clk),
        .reset_n     (reset_n),
        .tvalid      (tvalid),
        .tready      (tready),
        .payload     ({tdata, tstrb, tkeep, tlast, tid, tdest, tuser}),
        .valid_drop  (valid_drop),
        .payload_chg (payload_chg),
        .timeout     (timeout)
    );

    // Beats already accepted in the current packet; zero while idle.
    assign beats_eff    = (state == IN_PKT) ? pkt_beats : '0;
    assign pkt_long     = (MAX_PKT_BEATS > 0) && hs && !tlast &&
                          (beats_eff == PBW'(MAX_PKT_BEATS - 1));
    assign route_chg    = hs && (state == IN_PKT) && ((tid != cap_id) || (tdest != cap_dest));
    assign strb_no_keep = hs && |(tstrb & ~tkeep);

    assign err_now = {strb_no_keep, route_chg, pkt_long, timeout, payload_chg, valid_drop};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pkt_beats <= '0;
            cap_id    <= '0;
            cap_dest  <= '0;
        end else if (hs) begin
            if (tlast) begin
                state <= IDLE;
            end else if (state == IDLE) begin
                state     <= IN_PKT;
                pkt_beats <= PBW'(1);
                cap_id    <= tid;
                cap_dest  <= tdest;
            end else if (pkt_beats != '1) begin
                pkt_beats <= pkt_beats + 1'b1;
            end
        end
    end

    // A clear coincident with a new error still records that error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_vec_o    <= '0;
            err_sticky_o <= '0;
            first_err_o  <= ERR_NONE;
            beat_cnt_o   <= '0;
            pkt_cnt_o    <= '0;
        end else begin
            err_vec_o    <= err_now;
            err_sticky_o <= (clr_i ? '0 : err_sticky_o) | err_now;
            if (clr_i || first_err_o == ERR_NONE)
                first_err_o <= first_err_idx(err_now);
            if (clr_i)
                beat_cnt_o <= CNT_WIDTH'(hs);
            else if (hs && beat_cnt_o != '1)
                beat_cnt_o <= beat_cnt_o + 1'b1;
            if (clr_i)
                pkt_cnt_o <= CNT_WIDTH'(hs & tlast);
            else if (hs && tlast && pkt_cnt_o != '1)
                pkt_cnt_o <= pkt_cnt_o + 1'b1;
        end
    end

    assign err_o = |err_vec_o;

endmodule

// File: tb/tb_uvma_axis_prot_chkr.sv
// Scoreboard bench for the AXI-Stream protocol checker.
module tb_uvma_axis_prot_chkr;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clr_i;
    logic        tvalid, tready, tlast;
    logic [31:0] tdata;
    logic [3:0]  tstrb, tkeep, tid, tdest;
    logic [0:0]  tuser;
    logic [5:0]  err_vec_o, err_sticky_o;
    logic        err_o;
    logic [2:0]  first_err_o;
    logic [31:0] beat_cnt_o, pkt_cnt_o;

    int n_chk = 0;
    int n_err = 0;
    int exp_beats = 0;
    int exp_pkts  = 0;

    logic [5:0] q[$];
    logic [5:0] pend;
    logic       pend_v = 1'b0;

    always #5 clk = ~clk;

    uvma_axis_prot_chkr #(
        .DATA_WIDTH(32), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(1),
        .MAX_PKT_BEATS(8), .TIMEOUT_CYCLES(8), .CNT_WIDTH(32)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .clr_i(clr_i),
        .tvalid(tvalid), .tready(tready), .tlast(tlast),
        .tdata(tdata), .tstrb(tstrb), .tkeep(tkeep),
        .tid(tid), .tdest(tdest), .tuser(tuser),
        .err_vec_o(err_vec_o), .err_o(err_o), .err_sticky_o(err_sticky_o),
        .first_err_o(first_err_o), .beat_cnt_o(beat_cnt_o), .pkt_cnt_o(pkt_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Each entry is the set of violations the driven cycle should raise.
    task automatic drive(input logic v, input logic r, input logic l, input logic [31:0] d,
                         input logic [3:0] s, input logic [3:0] k, input logic [3:0] id,
                         input logic [3:0] dst, input logic c, input logic [5:0] exp);
        @(posedge clk); #1;
        tvalid = v; tready = r; tlast = l; tdata = d;
        tstrb = s; tkeep = k; tid = id; tdest = dst; clr_i = c;
        q.push_back(exp);
        if (c) begin exp_beats = 0; exp_pkts = 0; end
        if (v && r) begin exp_beats++; if (l) exp_pkts++; end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 6'h0);
    endtask

    task automatic chk_rst();
        chk("rst_vec", err_vec_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_sticky", err_sticky_o, 0);
        chk("rst_first", first_err_o, 7);
        chk("rst_beats", beat_cnt_o, 0);
        chk("rst_pkts", pkt_cnt_o, 0);
    endtask

    always @(posedge clk) begin
        if (q.size() > 0) begin
            pend   <= q.pop_front();
            pend_v <= 1'b1;
        end else begin
            pend_v <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (pend_v && reset_n) begin
            chk("err_vec", err_vec_o, pend);
            chk("err_o", err_o, |pend);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", n_chk, n_err);
        $fatal(1);
    end

    initial begin
        int lens[3] = '{4, 1, 7};
        reset_n = 1'b0; clr_i = 1'b0; tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
        tdata = '0; tstrb = 4'hF; tkeep = 4'hF; tid = '0; tdest = '0; tuser = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); chk_rst();
        @(posedge clk); #1; reset_n = 1'b1;

        // Clean traffic with random backpressure, stalls capped at 3 cycles.
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < lens[p]; b++) begin
                logic [31:0] d;
                int stalls;
                logic r;
                d = $urandom;
                stalls = 0;
                forever begin
                    r = (stalls == 3) ? 1'b1 : 1'($urandom_range(0, 1));
                    drive(1'b1, r, b == lens[p] - 1, d, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 6'h0);
                    stalls++;
                    if (r) break;
                end
                if ($urandom_range(0, 1) == 1) idle(1);
            end
        end
        idle(2);
        @(negedge clk);
        chk("clean_sticky", err_sticky_o, 0);
        chk("clean_first", first_err_o, 7);
        chk("clean_beats", beat_cnt_o, 12);
        chk("clean_pkts", pkt_cnt_o, 3);

        // Payload change while stalled.
        drive(1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 6'h00);
        drive(1'b1, 1'b0, 1'b1, 32'h5A5A5A5A, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 6'h02);
        drive(1'b1, 1'b1, 1'b1, 32'h5A5A5A5A, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 6'h00);
        idle(2);
        @(negedge clk);
        chk("chg_first", first_err_o, 1);
        chk("chg_sticky", err_sticky_o, 6'h02);

        // 20-cycle stall: one timeout pulse, raised on the ninth stalled cycle.
        for (int i = 0; i < 20; i++)
            drive(1'b1, 1'b0, 1'b1, 32'h1234, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0,
                  (i == 8) ? 6'h04 : 6'h00);
        drive(1'b1, 1'b1, 1'b1, 32'h1234, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 6'h00);
        idle(2);
        @(negedge clk);
        chk("to_sticky", err_sticky_o, 6'h06);
        chk("to_first", first_err_o, 1);

        // 10-beat packet against an 8-beat limit.
        for (int i = 1; i <= 10; i++)
            drive(1'b1, 1'b1, i == 10, 32'(i), 4'hF, 4'hF, 4'h1, 4'h2, 1'b0,
                  (i == 8) ? 6'h08 : 6'h00);
        idle(2);
        @(negedge clk);
        chk("long_sticky", err_sticky_o, 6'h0E);
        chk("long_beats", beat_cnt_o, 32'(exp_beats));
        chk("long_pkts", pkt_cnt_o, 32'(exp_pkts));

        // Route change and strobe-without-keep on the same beat.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 6'h00);
        drive(1'b1, 1'b1, 1'b0, 32'h11, 4'hF, 4'hF, 4'h2, 4'h0, 1'b0, 6'h00);
        drive(1'b1, 1'b1, 1'b1, 32'h22, 4'hF, 4'h7, 4'h3, 4'h0, 1'b0, 6'h30);
        idle(2);
        @(negedge clk);
        chk("route_first", first_err_o, 4);
        chk("route_sticky", err_sticky_o, 6'h30);
        chk("route_pkts", pkt_cnt_o, 32'(exp_pkts));

        // Reset mid-packet and mid-stall; release with tvalid low.
        drive(1'b1, 1'b1, 1'b0, 32'h33, 4'hF, 4'hF, 4'h1, 4'h0, 1'b0, 6'h00);
        drive(1'b1, 1'b0, 1'b0, 32'h44, 4'hF, 4'hF, 4'h1, 4'h0, 1'b0, 6'h00);
        drive(1'b1, 1'b0, 1'b0, 32'h44, 4'hF, 4'hF, 4'h1, 4'h0, 1'b0, 6'h00);
        @(posedge clk); #3;
        reset_n = 1'b0;
        q.delete();
        exp_beats = 0; exp_pkts = 0;
        @(negedge clk); chk_rst();
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1; tvalid = 1'b0; tready = 1'b0;
        q.push_back(6'h00);
        drive(1'b1, 1'b1, 1'b1, 32'h55, 4'hF, 4'hF, 4'h5, 4'h0, 1'b0, 6'h00);
        drive(1'b1, 1'b1, 1'b1, 32'h66, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 6'h20);
        // Clear coincident with a valid drop.
        drive(1'b1, 1'b0, 1'b1, 32'h77, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 6'h00);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 6'h01);
        idle(2);
        @(negedge clk);
        chk("clr_sticky", err_sticky_o, 6'h01);
        chk("clr_first", first_err_o, 0);
        chk("clr_beats", beat_cnt_o, 32'(exp_beats));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
